// File: rtl/xor_stream_checksum.sv
// ---------------------------------------------------------------------------
// xor_stream_checksum
//   Folds a packet of DATA_W-bit words into a running XOR checksum and reports
//   the checksum, its reduction parity and the beat count once per packet.
//   A packet closes on a beat carrying in_last, or on the beat that brings the
//   count to MAX_BEATS (force-close, flagged with out_err).
//
//   Build option: define CHK_ROTATE_EN to rotate the accumulator left by one
//   before each XOR, making the checksum sensitive to word order. Without it
//   the fold is a plain, order-insensitive XOR. Ports are identical either way.
//
// Ports
//   clk           in   1       clock, rising edge
//   rst_n         in   1       synchronous active-low reset
//   in_valid      in   1       input word valid
//   in_ready      out  1       block accepts input word (low only while a
//                              result is pending)
//   in_data       in   DATA_W  input word
//   in_last       in   1       final word of packet
//   out_valid     out  1       result valid
//   out_ready     in   1       downstream accepts result
//   out_checksum  out  DATA_W  XOR fold of all packet words
//   out_parity    out  1       ^out_checksum
//   out_count     out  CNT_W   beats in packet (1..MAX_BEATS)
//   out_err       out  1       packet force-closed at MAX_BEATS without in_last
//
// States
//   IDLE  | no beats taken for the current packet
//   ACCUM | at least one beat folded into the accumulator
//   HOLD  | result presented, waiting for out_ready
// ---------------------------------------------------------------------------
module xor_stream_checksum #(
  parameter  int DATA_W    = 8,
  parameter  int MAX_BEATS = 16,
  localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_checksum,
  output logic              out_parity,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t              state_q,  state_d;
  logic [DATA_W-1:0]   acc_q,    acc_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  logic [DATA_W-1:0]   chk_q,    chk_d;
  logic                par_q,    par_d;
  logic [CNT_W-1:0]    ocnt_q,   ocnt_d;
  logic                err_q,    err_d;
  logic                valid_q,  valid_d;

  logic [DATA_W-1:0]   acc_f;
  logic [DATA_W-1:0]   fold;
  logic [CNT_W-1:0]    cnt_inc;
  logic                beat;
  logic                close;

`ifdef CHK_ROTATE_EN
  assign acc_f = {acc_q[DATA_W-2:0], acc_q[DATA_W-1]};
`else
  assign acc_f = acc_q;
`endif

  assign in_ready = (state_q != HOLD);
  assign beat     = in_valid & in_ready;
  assign fold     = acc_f ^ in_data;
  assign cnt_inc  = cnt_q + 1'b1;
  // cnt never exceeds MAX_BEATS, so equality on the incremented value is the
  // full force-close condition.
  assign close    = beat & (in_last | (cnt_inc == CNT_W'(MAX_BEATS)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      chk_q   <= '0;
      par_q   <= 1'b0;
      ocnt_q  <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      chk_q   <= chk_d;
      par_q   <= par_d;
      ocnt_q  <= ocnt_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    chk_d   = chk_q;
    par_d   = par_q;
    ocnt_d  = ocnt_q;
    err_d   = err_q;
    valid_d = valid_q;

    case (state_q)
      IDLE, ACCUM: begin
        if (close) begin
          chk_d   = fold;
          par_d   = ^fold;
          ocnt_d  = cnt_inc;
          err_d   = ~in_last;
          valid_d = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = HOLD;
        end else if (beat) begin
          acc_d   = fold;
          cnt_d   = cnt_inc;
          state_d = ACCUM;
        end
      end
      HOLD: begin
        // Result fields are left untouched after the handshake; only the
        // valid flag drops.
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        acc_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  assign out_valid    = valid_q;
  assign out_checksum = chk_q;
  assign out_parity   = par_q;
  assign out_count    = ocnt_q;
  assign out_err      = err_q;

endmodule
